// File: rtl/vga_color_controller.sv
// 640x480@60Hz VGA timing generator driving a solid colour from switches.
// A 50 MHz clock is divided into a 25 MHz pixel enable that advances the counters.
module vga_color_controller #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] sw,
  output logic       clk_en_25MHz,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [2:0] blue,
  output logic       h_sync,
  output logic       v_sync
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_VIS_END    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          active;

  assign h_wrap = (h_cnt == H_LAST);
  assign active = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

  // Pixel enable: divide-by-two toggle
  always_ff @(posedge clk) begin
    if (rst) clk_en_25MHz <= 1'b0;
    else     clk_en_25MHz <= ~clk_en_25MHz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
    end else if (clk_en_25MHz) begin
      if (h_wrap) h_cnt <= '0;
      else        h_cnt <= h_cnt + CW'(1);
    end
  end

  // Line counter steps only on the enabled edge where the pixel counter wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      v_cnt <= '0;
    end else if (clk_en_25MHz && h_wrap) begin
      if (v_cnt == V_LAST) v_cnt <= '0;
      else                 v_cnt <= v_cnt + CW'(1);
    end
  end

  // Zero-latency decode of the counters; reset forces the idle levels
  always_comb begin
    red    = 3'd0;
    green  = 3'd0;
    blue   = 3'd0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    if (!rst) begin
      h_sync = !((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST));
      v_sync = !((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST));
      if (active) begin
        red   = sw[8:6];
        green = sw[5:3];
        blue  = sw[2:0];
      end
    end
  end

endmodule

// File: tb/tb_vga_color_controller.sv
// Directed bench for vga_color_controller: full-size instance plus a short-frame
// instance so vertical boundaries and frame wrap fit in a short run.
module tb_vga_color_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] sw;

  logic       en_d, hs_d, vs_d;
  logic [2:0] r_d, g_d, b_d;
  logic       en_s, hs_s, vs_s;
  logic [2:0] r_s, g_s, b_s;

  vga_color_controller dut (
    .clk(clk), .rst(rst), .sw(sw), .clk_en_25MHz(en_d),
    .red(r_d), .green(g_d), .blue(b_d), .h_sync(hs_d), .v_sync(vs_d)
  );

  // Short frame: 4 visible lines, sync on lines 6-7, 10 lines total
  vga_color_controller #(
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clk(clk), .rst(rst), .sw(sw), .clk_en_25MHz(en_s),
    .red(r_s), .green(g_s), .blue(b_s), .h_sync(hs_s), .v_sync(vs_s)
  );

  always #10 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   k = 0;
  int   phase = 0;
  int   scan_bad_d = 0;
  int   scan_bad_s = 0;
  int   hs_low = 0;
  int   first_fall = -1;
  int   second_fall = -1;
  int   vs_low_s = 0;
  logic hs_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // k = clk edges since reset released; outputs follow from k by arithmetic
  function automatic logic [11:0] model(input int kk, input int vt, input int vss,
                                        input int vvis, input logic r, input logic [8:0] s);
    int h, v;
    logic act, hs, vs;
    logic [8:0] c;
    h   = (kk / 2) % 800;
    v   = (kk / 1600) % vt;
    act = (h < 640) && (v < vvis);
    c   = (act && !r) ? s : 9'd0;
    hs  = r ? 1'b1 : !(h >= 656 && h <= 751);
    vs  = r ? 1'b1 : !(v >= vss && v <= vss + 1);
    return {1'(kk % 2), c, hs, vs};
  endfunction

  task automatic tick();
    logic [11:0] exp_d, exp_s;
    @(posedge clk);
    if (rst) k = 0;
    else     k++;
    #1;
    exp_d = model(k, 525, 490, 480, rst, sw);
    exp_s = model(k, 10, 6, 4, rst, sw);
    if ({en_d, r_d, g_d, b_d, hs_d, vs_d} !== exp_d) scan_bad_d++;
    if ({en_s, r_s, g_s, b_s, hs_s, vs_s} !== exp_s) scan_bad_s++;
    if (phase == 0) begin
      if (k < 1600 && hs_d == 1'b0) hs_low++;
      if (hs_prev && !hs_d) begin
        if (first_fall < 0)       first_fall = k;
        else if (second_fall < 0) second_fall = k;
      end
      hs_prev = hs_d;
      if (k < 16000 && vs_s == 1'b0) vs_low_s++;
    end
  endtask

  initial begin
    rst = 1'b1;
    sw  = 9'h1FF;
    tick();
    tick();
    check("rst_en",    32'(en_d), 32'd0);
    check("rst_rgb",   32'({r_d, g_d, b_d}), 32'd0);
    check("rst_hsync", 32'(hs_d), 32'd1);
    check("rst_vsync", 32'(vs_d), 32'd1);
    check("rst_rgb_s", 32'({r_s, g_s, b_s}), 32'd0);

    rst = 1'b0;
    #1;
    check("rel_en",  32'(en_d), 32'd0);
    check("rel_rgb", 32'({r_d, g_d, b_d}), 32'h1FF);

    for (int i = 1; i <= 19800; i++) begin
      tick();
      case (k)
        1:     check("en_k1", 32'(en_d), 32'd1);
        2:     check("en_k2", 32'(en_d), 32'd0);
        3:     check("en_k3", 32'(en_d), 32'd1);
        4:     check("en_k4", 32'(en_d), 32'd0);
        100: begin
          sw = 9'b111000000;
          #1;
          check("red_only", 32'({r_d, g_d, b_d}), 32'(9'b111000000));
        end
        1278:  check("h639_colour", 32'({r_d, g_d, b_d}), 32'(9'b111000000));
        1280:  check("h640_black",  32'({r_d, g_d, b_d}), 32'd0);
        1600: begin
          sw = 9'b000111000;
          #1;
          check("green_only", 32'({r_d, g_d, b_d}), 32'(9'b000111000));
        end
        3200: begin
          sw = 9'd0;
          #1;
          check("sw_zero", 32'({r_d, g_d, b_d}), 32'd0);
        end
        4800: begin
          sw = 9'b101010011;
          #1;
          check("mixed_s", 32'({r_s, g_s, b_s}), 32'(9'b101010011));
        end
        5000:  check("v_last_vis_s", 32'({r_s, g_s, b_s}), 32'(9'b101010011));
        6400: begin
          check("v_first_blank_s", 32'({r_s, g_s, b_s}), 32'd0);
          check("v4_vis_dflt",     32'({r_d, g_d, b_d}), 32'(9'b101010011));
        end
        9599:  check("vs_before_s", 32'(vs_s), 32'd1);
        9600:  check("vs_start_s",  32'(vs_s), 32'd0);
        12799: check("vs_end_s",    32'(vs_s), 32'd0);
        12800: check("vs_after_s",  32'(vs_s), 32'd1);
        15999: check("h799_v9_s",   32'({r_s, g_s, b_s, hs_s, vs_s}), 32'd3);
        16000: begin
          check("wrap_rgb_s", 32'({r_s, g_s, b_s}), 32'(9'b101010011));
          check("wrap_en_s",  32'(en_s), 32'd0);
        end
        19800: check("pre_rst_rgb", 32'({r_d, g_d, b_d}), 32'(9'b101010011));
        default: ;
      endcase
    end

    // Mid-frame reset at h=300 (line 12 default, line 2 short frame)
    phase = 1;
    rst = 1'b1;
    #1;
    check("rst_gate_rgb", 32'({r_d, g_d, b_d}), 32'd0);
    check("rst_gate_hs",  32'(hs_d), 32'd1);
    tick();
    check("mid_rst_en",   32'(en_d), 32'd0);
    check("mid_rst_rgb",  32'({r_d, g_d, b_d}), 32'd0);
    check("mid_rst_sync", 32'({hs_d, vs_d, hs_s, vs_s}), 32'hF);
    check("mid_rst_en_s", 32'(en_s), 32'd0);
    rst = 1'b0;
    #1;
    check("resume_rgb", 32'({r_d, g_d, b_d}), 32'(9'b101010011));
    for (int i = 1; i <= 1400; i++) begin
      tick();
      case (k)
        1:    check("resume_en",     32'(en_d), 32'd1);
        1311: check("resume_hs_pre", 32'(hs_d), 32'd1);
        1312: check("resume_hs",     32'(hs_d), 32'd0);
        default: ;
      endcase
    end

    check("scan_dflt",   32'(scan_bad_d), 32'd0);
    check("scan_short",  32'(scan_bad_s), 32'd0);
    check("hs_width",    32'(hs_low), 32'd192);
    check("hs_fall1",    32'(first_fall), 32'd1312);
    check("hs_fall2",    32'(second_fall), 32'd2912);
    check("vs_width_s",  32'(vs_low_s), 32'd3200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
